// File: rtl/decode_stage.sv
// RV32I/RV64I main decoder with one output pipeline register (1-cycle latency).
// in_ready_o = !out_valid_o | out_ready_i; a held instruction stays stable while execute stalls.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ALUOP_W  = 5,
  parameter int ILLCNT_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         instr_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [2:0]          funct3_o,
  output logic [XLEN-1:0]     imm_o,
  output logic                regwrite_o,
  output logic                alusrc_o,
  output logic                memwrite_o,
  output logic                memread_o,
  output logic                memtoreg_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic                illegal_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ILLCNT_W-1:0] ill_cnt_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(5'b01100);

  // Control vector order: regwrite, alusrc, memwrite, memread, memtoreg, branch, jump
  logic [6:0]          w_ctrl;
  logic [ALUOP_W-1:0]  w_aluop;
  logic                w_ill;
  logic [31:0]         w_imm32;
  logic [XLEN-1:0]     w_imm;
  logic                w_load;

  logic                r_valid;
  logic [XLEN-1:0]     r_pc;
  logic [4:0]          r_rd;
  logic [4:0]          r_rs1;
  logic [4:0]          r_rs2;
  logic [2:0]          r_funct3;
  logic [XLEN-1:0]     r_imm;
  logic [6:0]          r_ctrl;
  logic                r_ill;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ILLCNT_W-1:0] r_ill_cnt;

  always_comb begin
    w_ctrl  = '0;
    w_aluop = '0;
    w_ill   = 1'b0;
    w_imm32 = '0;
    case (instr_i[6:0])
      OP_R: begin
        w_ctrl  = 7'b1000000;
        w_aluop = ALU_ADD;
      end
      OP_I: begin
        w_ctrl  = 7'b1100000;
        w_aluop = ALU_ADD;
        w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_LOAD: begin
        w_ctrl  = 7'b1101100;
        w_aluop = ALU_ADD;
        w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        w_ctrl  = 7'b0110000;
        w_aluop = ALU_ADD;
        w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_BR: begin
        w_ctrl  = 7'b0000010;
        w_aluop = ALU_ADD;
        w_imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OP_LUI: begin
        w_ctrl  = 7'b1100000;
        w_imm32 = {instr_i[31:12], 12'b0};
      end
      OP_AUIPC: begin
        w_ctrl  = 7'b1100000;
        w_aluop = ALU_ADD;
        w_imm32 = {instr_i[31:12], 12'b0};
      end
      OP_JAL: begin
        w_ctrl  = 7'b1000001;
        w_aluop = ALU_ADD;
        w_imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OP_JALR: begin
        w_ctrl  = 7'b1100001;
        w_aluop = ALU_ADD;
        w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Signed cast widens the 32-bit immediate to XLEN without a zero-width replicate.
  assign w_imm      = XLEN'($signed(w_imm32));
  assign in_ready_o = ~r_valid | out_ready_i;
  assign w_load     = in_valid_i & in_ready_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_imm     <= '0;
      r_ctrl    <= '0;
      r_ill     <= 1'b0;
      r_aluop   <= '0;
      r_ill_cnt <= '0;
    end else begin
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid  <= 1'b1;
        r_pc     <= pc_i;
        r_rd     <= instr_i[11:7];
        r_rs1    <= instr_i[19:15];
        r_rs2    <= instr_i[24:20];
        r_funct3 <= instr_i[14:12];
        r_imm    <= w_imm;
        r_ctrl   <= w_ctrl;
        r_ill    <= w_ill;
        r_aluop  <= w_aluop;
      end else if (out_ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_load && w_ill && !(&r_ill_cnt)) begin
        r_ill_cnt <= r_ill_cnt + 1'b1;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign pc_o        = r_pc;
  assign rd_o        = r_rd;
  assign rs1_o       = r_rs1;
  assign rs2_o       = r_rs2;
  assign funct3_o    = r_funct3;
  assign imm_o       = r_imm;
  assign regwrite_o  = r_ctrl[6];
  assign alusrc_o    = r_ctrl[5];
  assign memwrite_o  = r_ctrl[4];
  assign memread_o   = r_ctrl[3];
  assign memtoreg_o  = r_ctrl[2];
  assign branch_o    = r_ctrl[1];
  assign jump_o      = r_ctrl[0];
  assign illegal_o   = r_ill;
  assign aluop_o     = r_aluop;
  assign ill_cnt_o   = r_ill_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances share stimulus and a table-driven model.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr, pc;

  logic        o_rdy, o_vld, o_rw, o_as, o_mw, o_mr, o_mt, o_br, o_jp, o_ill;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2, o_aluop;
  logic [2:0]  o_f3;
  logic [7:0]  o_cnt;

  logic        q_rdy, q_vld, q_rw, q_as, q_mw, q_mr, q_mt, q_br, q_jp, q_ill;
  logic [63:0] q_pc, q_imm;
  logic [4:0]  q_rd, q_rs1, q_rs2, q_aluop;
  logic [2:0]  q_f3;
  logic [7:0]  q_cnt;

  decode_stage #(.XLEN(32), .ALUOP_W(5), .ILLCNT_W(8)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(o_rdy),
    .instr_i(instr), .pc_i(pc), .out_valid_o(o_vld), .out_ready_i(out_ready), .pc_o(o_pc),
    .rd_o(o_rd), .rs1_o(o_rs1), .rs2_o(o_rs2), .funct3_o(o_f3), .imm_o(o_imm),
    .regwrite_o(o_rw), .alusrc_o(o_as), .memwrite_o(o_mw), .memread_o(o_mr), .memtoreg_o(o_mt),
    .branch_o(o_br), .jump_o(o_jp), .illegal_o(o_ill), .aluop_o(o_aluop), .ill_cnt_o(o_cnt)
  );

  decode_stage #(.XLEN(64), .ALUOP_W(5), .ILLCNT_W(8)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(q_rdy),
    .instr_i(instr), .pc_i({32'h0, pc}), .out_valid_o(q_vld), .out_ready_i(out_ready), .pc_o(q_pc),
    .rd_o(q_rd), .rs1_o(q_rs1), .rs2_o(q_rs2), .funct3_o(q_f3), .imm_o(q_imm),
    .regwrite_o(q_rw), .alusrc_o(q_as), .memwrite_o(q_mw), .memread_o(q_mr), .memtoreg_o(q_mt),
    .branch_o(q_br), .jump_o(q_jp), .illegal_o(q_ill), .aluop_o(q_aluop), .ill_cnt_o(q_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [63:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [6:0]  ctrl;
    logic        ill;
    logic [4:0]  aluop;
  } exp_t;

  // Opcode table rows; imm kind: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
  localparam logic [6:0] OPC  [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
  localparam logic [6:0] CTRL [9] = '{7'b1000000, 7'b1100000, 7'b1101100, 7'b0110000, 7'b0000010,
                                      7'b1100000, 7'b1100000, 7'b1000001, 7'b1100001};
  localparam logic [4:0] ALU  [9] = '{5'd12, 5'd12, 5'd12, 5'd12, 5'd12, 5'd0, 5'd12, 5'd12, 5'd12};
  localparam int         IMK  [9] = '{0, 1, 1, 2, 3, 4, 4, 5, 1};

  function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc_in);
    exp_t e;
    int   s, u, v;
    s = int'(ins);
    e = '{default: '0};
    e.vld = 1'b1;
    e.pc  = {32'h0, pc_in};
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.f3  = ins[14:12];
    e.ill = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (ins[6:0] == OPC[k]) begin
        e.ill   = 1'b0;
        e.ctrl  = CTRL[k];
        e.aluop = ALU[k];
        v = 0;
        case (IMK[k])
          1: v = s >>> 20;
          2: v = (s >>> 25) * 32 + int'(ins[11:7]);
          3: v = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
          4: begin u = s; u[11:0] = 12'h0; v = u; end
          5: v = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                 + int'(ins[30:21]) * 2;
          default: v = 0;
        endcase
        e.imm = 64'(longint'(v));
      end
    end
    return e;
  endfunction

  exp_t m;
  exp_t m_new;
  int   m_cnt = 0;
  bit   en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m     = '{default: '0};
      m_cnt = 0;
      en    = 1'b1;
    end else if (flush) begin
      m.vld = 1'b0;
    end else if (in_valid && (!m.vld || out_ready)) begin
      m_new = decode(instr, pc);
      if (m_new.ill && m_cnt < 255) m_cnt++;
      m = m_new;
    end else if (out_ready) begin
      m.vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("vld32", o_vld, m.vld);
      chk("rdy32", o_rdy, !m.vld || out_ready);
      chk("pc32", o_pc, m.pc[31:0]);
      chk("fields32", {o_rd, o_rs1, o_rs2, o_f3}, {m.rd, m.rs1, m.rs2, m.f3});
      chk("imm32", o_imm, m.imm[31:0]);
      chk("ctrl32", {o_rw, o_as, o_mw, o_mr, o_mt, o_br, o_jp}, m.ctrl);
      chk("ill32", o_ill, m.ill);
      chk("aluop32", o_aluop, m.aluop);
      chk("cnt32", o_cnt, m_cnt[7:0]);
      chk("vld64", {q_vld, q_rdy}, {m.vld, !m.vld || out_ready});
      chk("pc64", q_pc, m.pc);
      chk("imm64", q_imm, m.imm);
      chk("ctrl64", {q_rw, q_as, q_mw, q_mr, q_mt, q_br, q_jp, q_ill, q_aluop},
          {m.ctrl, m.ill, m.aluop});
      chk("fields64", {q_rd, q_rs1, q_rs2, q_f3}, {m.rd, m.rs1, m.rs2, m.f3});
      chk("cnt64", q_cnt, m_cnt[7:0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] PROG [9] = '{32'h002081B3, 32'hFFF00093, 32'h0040A103, 32'hFE112E23,
                                       32'hFE000EE3, 32'h123452B7, 32'h00001317, 32'hFFDFF0EF,
                                       32'h000080E7};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; pc = '0;
    cyc(); cyc();
    chk("rst_state", {o_vld, o_rdy, o_cnt, o_imm}, {1'b0, 1'b1, 8'd0, 32'd0});
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; instr = PROG[i]; pc = 32'h100 + 32'(i * 4);
      cyc();
      chk("load_vld", o_vld, 1'b1);
      if (i == 1) chk("addi_imm_rd", {o_imm, 27'd0, o_rd}, {32'hFFFFFFFF, 32'd1});
      if (i == 3 || i == 4 || i == 7) begin
        chk("neg4_imm32", o_imm, 32'hFFFFFFFC);
        chk("neg4_imm64", q_imm, 64'hFFFFFFFFFFFFFFFC);
      end
      if (i == 5) chk("lui_ctrl", {o_rw, o_as, o_aluop, o_imm}, {2'b11, 5'd0, 32'h12345000});
    end
    in_valid = 1'b0;
    cyc();
    chk("drain_vld", o_vld, 1'b0);

    in_valid = 1'b1; instr = 32'hFFF00093; pc = 32'h200; out_ready = 1'b1;
    cyc();
    instr = 32'h002081B3; pc = 32'h204; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_hold", {o_rdy, o_vld, o_pc, o_imm}, {1'b0, 1'b1, 32'h200, 32'hFFFFFFFF});
    end
    out_ready = 1'b1;
    cyc();
    chk("b2b_load", {o_vld, o_pc}, {1'b1, 32'h204});

    in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    flush = 1'b1; in_valid = 1'b1; instr = 32'h0; out_ready = 1'b1;
    cyc();
    chk("flush_vld_cnt", {o_vld, o_cnt}, {1'b0, 8'd0});
    flush = 1'b0;

    for (int i = 0; i < 300; i++) cyc();
    chk("ill_sat", {o_cnt, o_ill, o_rw, o_as, o_mw, o_mr, o_mt, o_br, o_jp, o_aluop},
        {8'd255, 1'b1, 7'd0, 5'd0});

    instr = 32'hFFF00093;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    chk("pre_rst_hold", o_vld, 1'b1);
    rst = 1'b1;
    cyc();
    chk("mid_rst", {o_vld, o_rdy, o_cnt, o_imm, o_rd}, {1'b0, 1'b1, 8'd0, 32'd0, 5'd0});
    rst = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
